// File: rtl/ring_traffic_endpoint.sv
// Ring NoC node endpoint: generates patterned traffic into a source queue, injects it
// under valid/ready, and sinks ejected packets while accumulating saturating statistics.
module ring_traffic_endpoint #(
  parameter int          NUM_NODES       = 8,
  parameter int          NODE_ID         = 0,
  parameter int          ID_WIDTH        = 16,
  parameter int          TS_WIDTH        = 16,
  parameter int          NUM_PACKETS     = 20,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          TRAFFIC_PATTERN = 0,
  parameter int          HOTSPOT_ID      = 0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  localparam int         PACKET_SIZE     = 1 + TS_WIDTH + 2 * ID_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [TS_WIDTH-1:0]    clk_counter,
  input  logic                   inject_tick,
  output logic [PACKET_SIZE-1:0] inj_pkt,
  input  logic                   inj_ready,
  input  logic [PACKET_SIZE-1:0] ej_pkt,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            total_packet_sent,
  output logic [63:0]            total_packet_recieve,
  output logic [63:0]            total_latency,
  output logic [31:0]            total_misroute,
  output logic [31:0]            total_inject_stall
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int GEN_W = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PACKET_SIZE-1:0] r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [GEN_W-1:0]       r_gen;
  logic [15:0]            r_lfsr;
  logic [63:0]            r_sent;
  logic [63:0]            r_recv;
  logic [63:0]            r_lat;
  logic [31:0]            r_mis;
  logic [31:0]            r_stall;

  function automatic logic [ID_WIDTH-1:0] f_dest(input logic [15:0] lfsr);
    int d;
    case (TRAFFIC_PATTERN)
      1:       d = int'({16'd0, lfsr}) % NUM_NODES;
      2:       d = (NODE_ID + 1) % NUM_NODES;
      3:       d = (NODE_ID + (NUM_NODES + 1) / 2 - 1) % NUM_NODES;
      4:       d = HOTSPOT_ID;
      default: d = NUM_NODES - 1 - NODE_ID;
    endcase
    // A node never addresses itself; fall through to its downstream neighbour.
    if (d == NODE_ID) d = (NODE_ID + 1) % NUM_NODES;
    return ID_WIDTH'(d);
  endfunction

  function automatic logic [63:0] f_sat_add64(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? '1 : s[63:0];
  endfunction

  function automatic logic [31:0] f_sat_inc32(input logic [31:0] a);
    return (&a) ? a : a + 32'd1;
  endfunction

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic                   w_empty;
  logic                   w_full;
  logic                   w_gen_done;
  logic                   w_gen_ok;
  logic                   w_push;
  logic                   w_stall;
  logic                   w_pop;
  logic                   w_start;
  logic                   w_last_out;
  logic [PACKET_SIZE-1:0] w_new_pkt;
  logic                   w_ej_vld;
  logic [TS_WIDTH-1:0]    w_ej_ts;
  logic                   w_ej_hit;
  logic [TS_WIDTH-1:0]    w_lat;
  logic                   w_unused_ej_src;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(QUEUE_DEPTH));
  assign w_gen_done = (r_gen == GEN_W'(NUM_PACKETS));
  assign w_gen_ok   = (r_state == S_RUN) && inject_tick && !w_gen_done;
  // Fullness uses registered occupancy only, so a same-cycle pop never frees a slot.
  assign w_push     = w_gen_ok && !w_full;
  assign w_stall    = w_gen_ok && w_full;
  assign w_pop      = !w_empty && inj_ready;
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_out = w_empty || ((r_count == CNT_W'(1)) && w_pop);
  assign w_new_pkt  = {1'b1, clk_counter, ID_WIDTH'(NODE_ID), f_dest(r_lfsr)};

  assign w_ej_vld        = ej_pkt[PACKET_SIZE-1];
  assign w_ej_ts         = ej_pkt[PACKET_SIZE-2 -: TS_WIDTH];
  assign w_ej_hit        = (ej_pkt[ID_WIDTH-1:0] == ID_WIDTH'(NODE_ID));
  assign w_lat           = clk_counter - w_ej_ts;
  assign w_unused_ej_src = ^ej_pkt[2*ID_WIDTH-1:ID_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
      S_RUN:          if (w_gen_done) w_state_nxt = w_last_out ? S_DONE : S_DRAIN;
      S_DRAIN:        if (w_last_out) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Source queue: circular buffer, head shown combinationally, zero word when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new_pkt;
  end

  assign inj_pkt = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen  <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (w_start) begin
      r_gen  <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (w_push) begin
      r_gen  <= r_gen + GEN_W'(1);
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Statistics; ejection is counted regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sent  <= '0;
      r_recv  <= '0;
      r_lat   <= '0;
      r_mis   <= '0;
      r_stall <= '0;
    end else if (w_start) begin
      r_sent  <= '0;
      r_recv  <= '0;
      r_lat   <= '0;
      r_mis   <= '0;
      r_stall <= '0;
    end else begin
      if (w_pop)   r_sent  <= f_sat_add64(r_sent, 64'd1);
      if (w_stall) r_stall <= f_sat_inc32(r_stall);
      if (w_ej_vld) begin
        if (w_ej_hit) begin
          r_recv <= f_sat_add64(r_recv, 64'd1);
          r_lat  <= f_sat_add64(r_lat, 64'(w_lat));
        end else begin
          r_mis  <= f_sat_inc32(r_mis);
        end
      end
    end
  end

  assign busy                 = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done                 = (r_state == S_DONE);
  assign total_packet_sent    = r_sent;
  assign total_packet_recieve = r_recv;
  assign total_latency        = r_lat;
  assign total_misroute       = r_mis;
  assign total_inject_stall   = r_stall;

endmodule
